// File: rtl/lcd_cmd_sequencer_if.sv
// Command handshake between the script sequencer (master) and the LCD image controller (slave).
interface lcd_cmd_sequencer_if;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;

    modport master (output cmd, output cmd_valid, input busy, input done);
    modport slave  (input cmd, input cmd_valid, output busy, output done);
endinterface

// File: rtl/lcd_cmd_sequencer.sv
// Script-driven command source for the LCD image controller: fetches words from a sync ROM,
// expands repeat counts and obeys the busy/done handshake. Optional watchdog: LCD_SEQ_WDOG_EN.
module lcd_cmd_sequencer #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  scr_rd,
    output logic [ADDR_W-1:0]     scr_A,
    input  logic [7:0]            scr_Q,
    lcd_cmd_sequencer_if.master   ctl,
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic                  err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WAIT_RDY,
        S_ISSUE,
        S_GUARD,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cmd_r;
    logic [3:0]  rep_r;
    logic [3:0]  cmd_q;
    logic [3:0]  code;
    logic        last_addr;
    logic        restart;
    logic        addr_inc;
    logic        rep_dec;
    logic        in_wait;
    logic        timeout;

    assign code      = scr_Q[3:0];
    assign last_addr = &scr_A;
    assign restart   = start && ((state == S_IDLE) || (state == S_FINISH));
    assign in_wait   = (state == S_WAIT_RDY) || (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        addr_inc   = 1'b0;
        rep_dec    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                state_next = S_LATCH;
            end
            S_LATCH: begin
                if (code == 4'd15) begin
                    state_next = S_FINISH;
                end else if (code >= 4'd12) begin
                    // A reserved word at the top address is treated as the implicit END
                    if (last_addr) begin
                        state_next = S_FINISH;
                    end else begin
                        addr_inc   = 1'b1;
                        state_next = S_FETCH;
                    end
                end else begin
                    state_next = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (!ctl.busy) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                state_next = (cmd_r == 4'd0) ? S_WAIT_DONE : S_GUARD;
            end
            S_GUARD: begin
                state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!ctl.busy) begin
                    if (rep_r != 4'd0) begin
                        rep_dec    = 1'b1;
                        state_next = S_WAIT_RDY;
                    end else if (last_addr) begin
                        state_next = S_FINISH;
                    end else begin
                        addr_inc   = 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (ctl.done) state_next = S_FINISH;
            end
            S_FINISH: begin
                if (start) state_next = S_FETCH;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (timeout) begin
            state_next = S_FINISH;
            addr_inc   = 1'b0;
            rep_dec    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scr_A <= '0;
            cmd_r <= 4'd0;
            rep_r <= 4'd0;
            cmd_q <= 4'd0;
        end else begin
            if (restart) begin
                scr_A <= '0;
            end else if (addr_inc) begin
                scr_A <= scr_A + 1'b1;
            end
            if (state == S_LATCH) begin
                cmd_r <= scr_Q[3:0];
                rep_r <= scr_Q[7:4];
            end else if (rep_dec) begin
                rep_r <= rep_r - 1'b1;
            end
            // cmd keeps showing the last issued code between strobes
            if ((state == S_WAIT_RDY) && (state_next == S_ISSUE)) begin
                cmd_q <= cmd_r;
            end
        end
    end

`ifdef LCD_SEQ_WDOG_EN
    localparam int WdW = $clog2(TIMEOUT + 1);

    logic [WdW-1:0] wd_cnt;
    logic           err_q;

    // Fires on the last cycle of a wait that has lasted TIMEOUT cycles without progress
    assign timeout = in_wait && (wd_cnt == WdW'(TIMEOUT - 1)) &&
                     (((state == S_WAIT_RDY)  &&  ctl.busy) ||
                      ((state == S_WAIT_BUSY) &&  ctl.busy) ||
                      ((state == S_WAIT_DONE) && !ctl.done));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if ((state_next != state) || !in_wait) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (restart) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0) || in_wait;
    assign timeout        = 1'b0;
    assign err            = 1'b0;
`endif

    assign scr_rd        = (state == S_FETCH);
    assign ctl.cmd       = cmd_q;
    assign ctl.cmd_valid = (state == S_ISSUE);
    assign seq_busy      = (state != S_IDLE) && (state != S_FINISH);
    assign seq_done      = (state == S_FINISH);

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Scoreboard bench for lcd_cmd_sequencer: a script ROM and controller model drive the DUT, and a
// monitor checks each strobe against the expected-command queue.
module tb_lcd_cmd_sequencer;

    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              scr_rd;
    logic [ADDR_W-1:0] scr_A;
    logic [7:0]        scr_Q = 8'h00;
    logic              seq_busy;
    logic              seq_done;
    logic              err;

    lcd_cmd_sequencer_if ctl ();

    lcd_cmd_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .scr_rd   (scr_rd),
        .scr_A    (scr_A),
        .scr_Q    (scr_Q),
        .ctl      (ctl),
        .seq_busy (seq_busy),
        .seq_done (seq_done),
        .err      (err)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [64];

    always @(posedge clk) begin
        if (scr_rd) scr_Q <= rom[scr_A];
    end

    // Controller model: busy for 4 cycles after each strobe (when enabled), done 3 cycles after WRITE
    bit   busy_mode = 1'b0;
    bit   stuck_en  = 1'b0;
    int   bcnt;
    int   dcnt;
    logic stuck;
    logic done_r;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt   <= 0;
            dcnt   <= 0;
            stuck  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (ctl.cmd_valid && busy_mode) bcnt <= 4;
            else if (bcnt != 0)             bcnt <= bcnt - 1;
            if (!stuck_en)                  stuck <= 1'b0;
            else if (ctl.cmd_valid)         stuck <= 1'b1;
            if (ctl.cmd_valid && ctl.cmd == 4'd0) dcnt <= 3;
            else if (dcnt > 1)                    dcnt <= dcnt - 1;
            else if (dcnt == 1) begin
                dcnt   <= 0;
                done_r <= 1'b1;
            end
            if (start) done_r <= 1'b0;
        end
    end

    assign ctl.busy = stuck || (bcnt != 0);
    assign ctl.done = done_r;

    logic [3:0] exp_q [$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   strobes = 0;
    int   fetch0 = 0;
    int   last_strobe = -100;
    int   done_cyc = 0;
    int   sd_cyc = 0;
    logic done_prev = 1'b0;
    logic sd_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: pops the expected queue on every strobe and tracks event timing
    always @(negedge clk) begin
        logic [3:0] exp_cmd;
        if (!reset) begin
            if (ctl.cmd_valid) begin
                strobes++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_strobe: got cmd=%0d, expected no strobe", ctl.cmd);
                end else begin
                    exp_cmd = exp_q.pop_front();
                    checkOutput("strobe_cmd", 32'(ctl.cmd), 32'(exp_cmd));
                end
                if (last_strobe >= 0) checkOutput("strobe_spacing_ge3", 32'((cyc - last_strobe) >= 3), 32'd1);
                last_strobe = cyc;
            end
            if (scr_rd && scr_A == '0) fetch0++;
            if (ctl.done && !done_prev) done_cyc = cyc;
            if (seq_done && !sd_prev) sd_cyc = cyc;
            done_prev = ctl.done;
            sd_prev   = seq_done;
        end
    end

    task automatic loadRom(input logic [7:0] fill);
        for (int i = 0; i < 64; i++) rom[i] = fill;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic applyStimulus(input bit bmode, input int budget);
        int n;
        busy_mode = bmode;
        pulseStart();
        n = 0;
        while (!seq_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        checkOutput("finish_within_budget", 32'(seq_done), 32'd1);
    endtask

    task automatic checkQueueEmpty(input string name);
        checkOutput(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int base;
        int f0;
        int n;
        int sc;

        loadRom(8'hFF);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", 32'({ctl.cmd, ctl.cmd_valid, seq_busy, seq_done, err, scr_rd, scr_A}), 32'd0);

        // A start pulse while reset is held must be ignored
        rom[0] = 8'h01;
        rom[1] = 8'h0F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("start_during_reset_ignored", 32'({seq_busy, seq_done, scr_rd}), 32'd0);

        // Single command then END, busy held low
        loadRom(8'hFF);
        rom[0] = 8'h02;
        rom[1] = 8'h0F;
        exp_q.push_back(4'd2);
        applyStimulus(1'b0, 100);
        checkQueueEmpty("a_all_strobes_seen");
        checkOutput("a_scr_A", 32'(scr_A), 32'd1);
        checkOutput("a_cmd_held", 32'(ctl.cmd), 32'd2);
        checkOutput("a_seq_busy", 32'(seq_busy), 32'd0);
        checkOutput("a_err", 32'(err), 32'd0);

        // Repeat expansion and terminal WRITE with the busy/done model
        loadRom(8'hFF);
        rom[0] = 8'h35;
        rom[1] = 8'h00;
        for (int i = 0; i < 4; i++) exp_q.push_back(4'd5);
        exp_q.push_back(4'd0);
        applyStimulus(1'b1, 300);
        checkQueueEmpty("b_all_strobes_seen");
        checkOutput("b_done_to_seq_done", 32'(sd_cyc - done_cyc), 32'd1);
        checkOutput("b_scr_A", 32'(scr_A), 32'd1);

        // Reserved codes are skipped
        loadRom(8'hFF);
        rom[0] = 8'h0C;
        rom[1] = 8'h0E;
        rom[2] = 8'h09;
        rom[3] = 8'h0F;
        exp_q.push_back(4'd9);
        applyStimulus(1'b0, 100);
        checkQueueEmpty("c_only_cmd9");
        checkOutput("c_scr_A", 32'(scr_A), 32'd3);

        // Full ROM of code 1 with no END: implicit end at the top address
        loadRom(8'h01);
        for (int i = 0; i < 64; i++) exp_q.push_back(4'd1);
        base = strobes;
        f0   = fetch0;
        applyStimulus(1'b0, 1000);
        checkQueueEmpty("d_all_strobes_seen");
        checkOutput("d_strobe_count", 32'(strobes - base), 32'd64);
        checkOutput("d_scr_A", 32'(scr_A), 32'd63);
        checkOutput("d_fetch_addr0_once", 32'(fetch0 - f0), 32'd1);

        // Reset during WAIT_BUSY of the second repeat
        loadRom(8'hFF);
        rom[0] = 8'h25;
        rom[1] = 8'h0F;
        for (int i = 0; i < 3; i++) exp_q.push_back(4'd5);
        busy_mode = 1'b1;
        base = strobes;
        pulseStart();
        n = 0;
        while ((strobes - base) < 2 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("e_second_strobe_seen", 32'(strobes - base), 32'd2);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("e_reset_outputs_zero", 32'({ctl.cmd, ctl.cmd_valid, seq_busy, seq_done, err, scr_rd, scr_A}), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = strobes;
        repeat (20) @(negedge clk);
        checkOutput("e_no_strobe_after_reset", 32'(strobes - base), 32'd0);
        for (int i = 0; i < 3; i++) exp_q.push_back(4'd5);
        f0 = fetch0;
        applyStimulus(1'b1, 300);
        checkQueueEmpty("e_replay_strobes");
        checkOutput("e_replay_from_addr0", 32'(fetch0 - f0), 32'd1);

        // Busy stuck high after the first strobe
        loadRom(8'hFF);
        rom[0] = 8'h01;
        rom[1] = 8'h0F;
        exp_q.push_back(4'd1);
        busy_mode = 1'b0;
        stuck_en  = 1'b1;
        base = strobes;
        pulseStart();
        n = 0;
        while ((strobes - base) < 1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("f_first_strobe_seen", 32'(strobes - base), 32'd1);
        sc = last_strobe;
        repeat (40) @(negedge clk);
        #1;
`ifdef LCD_SEQ_WDOG_EN
        checkOutput("f_wdog_err", 32'(err), 32'd1);
        checkOutput("f_wdog_seq_done", 32'(seq_done), 32'd1);
        checkOutput("f_wdog_timing", 32'(sd_cyc - sc), 32'd18);
`else
        checkOutput("f_err_stays_0", 32'(err), 32'd0);
        checkOutput("f_still_waiting", 32'({seq_busy, seq_done}), 32'b10);
`endif
        stuck_en = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
